// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and row-write output bundle of the instruction memory loader.
// slave = loader side, master = host / controller side.
interface instr_mem_loader_if #(
  parameter int ROW_W = 15
);
  logic             start;
  logic [ROW_W-1:0] base_row;
  logic             s_valid;
  logic [7:0]       s_data;
  logic             s_last;
  logic             s_ready;
  logic             wr_vld;
  logic [ROW_W-1:0] wr_addr;
  logic [63:0]      wr_data;
  logic             busy;
  logic             done;
  logic             err;
  logic [17:0]      byte_cnt;

  modport slave (
    input  start, base_row, s_valid, s_data, s_last,
    output s_ready, wr_vld, wr_addr, wr_data, busy, done, err, byte_cnt
  );

  modport master (
    output start, base_row, s_valid, s_data, s_last,
    input  s_ready, wr_vld, wr_addr, wr_data, busy, done, err, byte_cnt
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Packs a little-endian byte stream into 64-bit instruction rows, one write per row;
// pads the final partial row and drops the rest of the image once the top row has been written.
module instr_mem_loader #(
  parameter int         ROW_W    = 15,
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input logic               clk,
  input logic               rst_n,
  instr_mem_loader_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_WRITE, S_SINK, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [ROW_W-1:0] r_row;
  logic [63:0]      r_stage;
  logic [2:0]       r_lane;
  logic             r_last;
  logic             r_err;
  logic [17:0]      r_byte_cnt;
  logic             w_s_ready;
  logic             w_wr_vld;
  logic             w_busy;
  logic             w_done;
  logic             w_hs;
  logic             w_row_end;
  logic             w_row_max;

  assign w_hs      = w_s_ready & bus.s_valid;
  assign w_row_end = (r_lane == 3'd7) | bus.s_last;
  assign w_row_max = (r_row == {ROW_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_s_ready = 1'b0;
    w_wr_vld  = 1'b0;
    w_busy    = 1'b1;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_next = S_FILL;
      end
      S_FILL: begin
        w_s_ready = 1'b1;
        if (w_hs && w_row_end) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_wr_vld = 1'b1;
        if (r_last)         w_next = S_DONE;
        else if (w_row_max) w_next = S_SINK;
        else                w_next = S_FILL;
      end
      S_SINK: begin
        w_s_ready = 1'b1;
        if (w_hs && bus.s_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row      <= '0;
      r_stage    <= '0;
      r_lane     <= '0;
      r_last     <= 1'b0;
      r_err      <= 1'b0;
      r_byte_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_row      <= bus.base_row;
            r_stage    <= {8{PAD_BYTE}};
            r_lane     <= '0;
            r_last     <= 1'b0;
            r_err      <= 1'b0;
            r_byte_cnt <= '0;
          end
        end
        S_FILL: begin
          if (w_hs) begin
            r_stage[{r_lane, 3'b000} +: 8] <= bus.s_data;
            r_lane <= r_lane + 3'd1;
            if (r_byte_cnt != {18{1'b1}}) r_byte_cnt <= r_byte_cnt + 18'd1;
            if (w_row_end) r_last <= bus.s_last;
          end
        end
        S_WRITE: begin
          // Lane index has already wrapped to 0 after a full row, so only row/staging advance here.
          if (!r_last) begin
            if (w_row_max) begin
              r_err <= 1'b1;
            end else begin
              r_row   <= r_row + ROW_W'(1);
              r_stage <= {8{PAD_BYTE}};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.s_ready  = w_s_ready;
  assign bus.wr_vld   = w_wr_vld;
  assign bus.wr_addr  = r_row;
  assign bus.wr_data  = r_stage;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.err      = r_err;
  assign bus.byte_cnt = r_byte_cnt;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Drives two loaders (pad 00 and pad 0B) with identical streams; a queue model of expected
// row writes, error and byte count is checked every cycle, plus literal row values per test.
module tb_instr_mem_loader;
  localparam int ROW_W = 15;

  typedef struct packed {
    logic [ROW_W-1:0] addr;
    logic [63:0]      data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_mem_loader_if #(.ROW_W(ROW_W)) bus0 ();
  instr_mem_loader_if #(.ROW_W(ROW_W)) bus1 ();

  instr_mem_loader #(.ROW_W(ROW_W), .PAD_BYTE(8'h00)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  instr_mem_loader #(.ROW_W(ROW_W), .PAD_BYTE(8'h0B)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  assign bus1.start    = bus0.start;
  assign bus1.base_row = bus0.base_row;
  assign bus1.s_valid  = bus0.s_valid;
  assign bus1.s_data   = bus0.s_data;
  assign bus1.s_last   = bus0.s_last;

  int  passed = 0;
  int  total  = 0;
  wr_t exp_q0[$];
  wr_t exp_q1[$];
  wr_t log0[$];
  wr_t log1[$];
  bit  exp_err;
  int  exp_cnt;
  int  done_cnt = 0;
  bit  prev_vld0 = 1'b0;
  bit  prev_vld1 = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Expected rows: ceil(n/8) rows from base, truncated at the top of the row space.
  task automatic model_load(input logic [ROW_W-1:0] base, input logic [7:0] img[$]);
    int n, rows, avail, wr;
    wr_t e0, e1;
    n     = img.size();
    rows  = (n + 7) / 8;
    avail = (1 << ROW_W) - int'(base);
    wr    = (rows < avail) ? rows : avail;
    exp_err = (rows > avail);
    exp_cnt = exp_err ? wr * 8 : n;
    for (int r = 0; r < wr; r++) begin
      e0.addr = base + ROW_W'(r);
      e1.addr = e0.addr;
      e0.data = '0;
      e1.data = {8{8'h0B}};
      for (int k = 0; k < 8; k++) begin
        if (r * 8 + k < n) begin
          e0.data[k*8 +: 8] = img[r*8 + k];
          e1.data[k*8 +: 8] = img[r*8 + k];
        end
      end
      exp_q0.push_back(e0);
      exp_q1.push_back(e1);
    end
  endtask

  task automatic check_dut(input int idx, input logic vld, input logic [ROW_W-1:0] addr,
                           input logic [63:0] data, input logic dn, input logic bsy,
                           input logic er, input logic [17:0] cnt, input bit pv);
    wr_t e, a;
    int  left;
    a.addr = addr;
    a.data = data;
    if (vld) begin
      if (idx == 0) log0.push_back(a); else log1.push_back(a);
      left = (idx == 0) ? exp_q0.size() : exp_q1.size();
      if (left == 0) begin
        chk($sformatf("spurious_wr%0d", idx), vld, 1'b0);
      end else begin
        e = (idx == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk($sformatf("wr_addr%0d", idx), addr, e.addr);
        chk($sformatf("wr_data%0d", idx), data, e.data);
      end
    end
    if (dn) begin
      left = (idx == 0) ? exp_q0.size() : exp_q1.size();
      chk($sformatf("done_busy%0d", idx), bsy, 1'b1);
      chk($sformatf("done_rows_left%0d", idx), left, 0);
      chk($sformatf("done_err%0d", idx), er, exp_err);
      chk($sformatf("done_cnt%0d", idx), cnt, 64'(exp_cnt));
      if (!exp_err) chk($sformatf("done_after_wr%0d", idx), pv, 1'b1);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check_dut(0, bus0.wr_vld, bus0.wr_addr, bus0.wr_data, bus0.done, bus0.busy,
                bus0.err, bus0.byte_cnt, prev_vld0);
      check_dut(1, bus1.wr_vld, bus1.wr_addr, bus1.wr_data, bus1.done, bus1.busy,
                bus1.err, bus1.byte_cnt, prev_vld1);
      if (bus0.done) done_cnt++;
      prev_vld0 = bus0.wr_vld;
      prev_vld1 = bus1.wr_vld;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit last);
    bit r;
    int c;
    c = 0;
    bus0.s_valid = 1'b1;
    bus0.s_data  = b;
    bus0.s_last  = last;
    do begin
      r = bus0.s_ready;
      @(posedge clk); #1;
      c++;
    end while (!r && c < 100);
    if (!r) chk("byte_accept_timeout", r, 1'b1);
    bus0.s_valid = 1'b0;
    bus0.s_last  = 1'b0;
  endtask

  task automatic do_start(input logic [ROW_W-1:0] base);
    bus0.base_row = base;
    bus0.start    = 1'b1;
    @(posedge clk); #1;
    bus0.start    = 1'b0;
    bus0.base_row = ~base;
    chk("busy_after_start", bus0.busy, 1'b1);
    chk("ready_after_start", bus0.s_ready, 1'b1);
    chk("err_cleared", bus0.err, 1'b0);
    chk("cnt_cleared", bus0.byte_cnt, 18'd0);
  endtask

  task automatic run_load(input logic [ROW_W-1:0] base, input logic [7:0] img[$],
                          input bit gaps, input bit inject);
    int d, c;
    log0.delete();
    log1.delete();
    model_load(base, img);
    d = done_cnt;
    do_start(base);
    for (int i = 0; i < img.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      if (inject && i == 5) begin
        bus0.start    = 1'b1;
        bus0.base_row = 15'h1234;
      end
      send_byte(img[i], i == img.size() - 1);
      bus0.start = 1'b0;
    end
    c = 0;
    while (done_cnt == d && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk("done_pulses", done_cnt - d, 1);
    @(posedge clk); #1;
    chk("idle_after_done", bus0.busy, 1'b0);
    chk("done_one_cycle", bus0.done, 1'b0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", bus0.s_ready, 1'b0);
    chk("rst_wr_vld", {bus0.wr_vld, bus1.wr_vld}, 2'b00);
    chk("rst_wr_addr", bus0.wr_addr, 15'd0);
    chk("rst_wr_data0", bus0.wr_data, 64'd0);
    chk("rst_wr_data1", bus1.wr_data, 64'd0);
    chk("rst_busy", bus0.busy, 1'b0);
    chk("rst_done", bus0.done, 1'b0);
    chk("rst_err", bus0.err, 1'b0);
    chk("rst_cnt", bus0.byte_cnt, 18'd0);
  endtask

  task automatic chk_seq16(input logic [ROW_W-1:0] base, input string tag);
    chk({tag, "_rows"}, log0.size(), 2);
    if (log0.size() == 2) begin
      chk({tag, "_addr0"}, log0[0].addr, base);
      chk({tag, "_data0"}, log0[0].data, 64'h0706050403020100);
      chk({tag, "_addr1"}, log0[1].addr, base + 15'd1);
      chk({tag, "_data1"}, log0[1].data, 64'h0F0E0D0C0B0A0908);
    end
    chk({tag, "_cnt"}, bus0.byte_cnt, 18'd16);
    chk({tag, "_err"}, bus0.err, 1'b0);
  endtask

  initial begin
    logic [7:0] seq16[$];
    logic [7:0] abc[$];
    logic [7:0] ovf[$];
    for (int i = 0; i < 16; i++) seq16.push_back(8'(i));
    abc = '{8'hAA, 8'hBB, 8'hCC};
    for (int i = 0; i < 12; i++) ovf.push_back(8'(8'h40 + i));

    bus0.start = 1'b0; bus0.base_row = '0; bus0.s_valid = 1'b0;
    bus0.s_data = '0; bus0.s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_load(15'h0010, seq16, 1'b0, 1'b0);
    chk_seq16(15'h0010, "seq");

    run_load(15'h0000, abc, 1'b0, 1'b0);
    chk("abc_rows", log0.size(), 1);
    if (log0.size() == 1) chk("abc_data_pad00", log0[0].data, 64'h0000000000CCBBAA);
    if (log1.size() == 1) chk("abc_data_pad0b", log1[0].data, 64'h0B0B0B0B0BCCBBAA);
    chk("abc_cnt", bus0.byte_cnt, 18'd3);

    run_load(15'h7FFF, ovf, 1'b0, 1'b0);
    chk("ovf_rows", log0.size(), 1);
    if (log0.size() == 1) begin
      chk("ovf_addr", log0[0].addr, 15'h7FFF);
      chk("ovf_data", log0[0].data, 64'h4746454443424140);
    end
    chk("ovf_err", bus0.err, 1'b1);
    chk("ovf_cnt", bus0.byte_cnt, 18'd8);

    run_load(15'h0010, seq16, 1'b1, 1'b1);
    chk_seq16(15'h0010, "gap");

    // Abort after 5 bytes: nothing may be written, all outputs back to reset values.
    log0.delete();
    log1.delete();
    model_load(15'h0020, seq16);
    do_start(15'h0020);
    for (int i = 0; i < 5; i++) send_byte(seq16[i], 1'b0);
    rst_n = 1'b0;
    #2;
    chk_reset_vals();
    chk("abort_no_wr", log0.size(), 0);
    exp_q0.delete();
    exp_q1.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_load(15'h0030, seq16, 1'b0, 1'b0);
    chk_seq16(15'h0030, "fresh");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Host-side loader sitting directly upstream of the instruction memory controller's write port. It accepts a WASM code image as a byte stream with a valid/ready handshake and packs bytes little-endian into 64-bit rows. It issues one-cycle row writes: `wr_vld`, a 15-bit row address, and 64-bit data, where byte lane j maps to bank j. It pads the final partial row, counts bytes, and flags an address overflow; `busy` keeps the core from fetching during a load.

## Interface
- `ROW_W`, default 15: row address width (32768 rows × 8 bytes).
- `PAD_BYTE`, default 8'h00: fill value for unused lanes of the final partial row.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: one-cycle load request; sampled only in IDLE.
- `base_row` input ROW_W: first row to write; captured on accepted `start`.
- `s_valid` input 1: stream byte valid.
- `s_data` input 8: stream byte.
- `s_last` input 1: marks final byte of image; qualified by `s_valid`.
- `s_ready` output 1: loader accepts byte this cycle.
- `wr_vld` output 1: row write strobe, one cycle per row; to controller `wr_vld`.
- `wr_addr` output ROW_W: row address; to controller `i_instr_mem_wr_addr`.
- `wr_data` output 64: row data, byte k in bits [8k+7:8k].
- `busy` output 1: high from accepted `start` until DONE completes.
- `done` output 1: one-cycle pulse at end of load.
- `err` output 1: sticky overflow flag; cleared by next accepted `start`.
- `byte_cnt` output 18: bytes accepted in current/last load; cleared by accepted `start`.

## Operation
- States: IDLE, FILL, WRITE, SINK, DONE.
- IDLE: `s_ready`=0, `busy`=0. On `start`:
  - capture `base_row` into row register;
  - clear lane index, `byte_cnt` and `err`;
  - preset all lanes of the staging register to `PAD_BYTE`;
  - go to FILL.
- FILL: `s_ready`=1. On handshake (`s_valid` & `s_ready`):
  - store `s_data` in lane = lane index;
  - increment lane index (3-bit, wraps 7→0) and `byte_cnt`;
  - if lane index was 7 or `s_last`=1, go to WRITE and latch the last flag.
- WRITE: `s_ready`=0, `wr_vld`=1 for exactly one cycle, `wr_addr`=row register, `wr_data`=staging register. Next state:
  - last flag set → DONE;
  - else row register = 0x7FFF → set `err`, go to SINK;
  - else row register +1, staging preset to `PAD_BYTE`, go to FILL.
- SINK: `s_ready`=1; bytes are discarded and not counted. On handshake with `s_last` → DONE.
- DONE: `done`=1 for one cycle; `busy` is still high in this cycle; next state IDLE.
- `start` outside IDLE is ignored. `s_last` with lane index 7 produces a single full write; no extra pad row is written.
- An image whose byte count is a multiple of 8 writes exactly count/8 rows; otherwise it writes ceil(count/8) rows, the final row padded in its upper lanes.
- `byte_cnt` saturates at 2^18−1.

## Timing
- Reset values: state IDLE; `s_ready`=0, `wr_vld`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `err`=0, `byte_cnt`=0; staging register 0.
- Reset asserted mid-load returns to IDLE immediately. No partial row is written, and the controller sees `wr_vld` drop asynchronously.
- `start` at cycle t: FILL and `busy`=1 from t+1.
- The 8th byte (or `s_last`) accepted at cycle t: `wr_vld`=1 at t+1, FILL resumes at t+2.
- Maximum throughput is 8 bytes per 9 cycles.
- Final write at cycle t: `done` at t+1, IDLE at t+2.
- `wr_vld`, `wr_addr`, `wr_data` are driven from registers (no combinational path from stream inputs).
- `s_ready` is a function of state only.

## Test plan
- Reset, then `start` with base_row=0x0010 and a 16-byte stream 0x00..0x0F with `s_last` on 0x0F:
  - two writes, row 0x0010 data 0x0706050403020100 and row 0x0011 data 0x0F0E0D0C0B0A0908;
  - `done` pulses one cycle later; `byte_cnt`=16, `err`=0.
- 3-byte stream 0xAA,0xBB,0xCC with `s_last` on the third byte, base_row=0 → one write to row 0 with data 0x0000000000CCBBAA; `byte_cnt`=3.
- Same 3-byte stream with PAD_BYTE=8'h0B → row 0 data 0x0B0B0B0B0BCCBBAA.
- base_row=0x7FFF, 12 bytes:
  - row 0x7FFF written with bytes 0–7, then `err`=1;
  - bytes 8–11 are accepted and dropped, no second write;
  - `done` follows `s_last`; `byte_cnt`=8.
- Random `s_valid` gaps and a `start` pulse injected mid-load → identical write data and addresses as the gap-free run; the mid-load `start` has no effect.
- Assert `rst_n` low after 5 bytes of a load → all outputs at reset values and no `wr_vld`; a subsequent fresh load completes correctly.
